// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/clear sequencer: load-use stall, branch flush, mult/div occupancy, SYSCALL halt.
// Define HAZARD_PERF_EN to add the perf_stall/perf_flush event counters.
module pipe_hazard_ctrl #(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_wbreg,
   input  logic       ex_branch_taken,
   input  logic       ex_muldiv,
   input  logic       wb_syscall,
   input  logic       wb_halt_req,
   input  logic       resume,
   output logic       en_pc,
   output logic       en_ifid,
   output logic       clr_ifid,
   output logic       en_idex,
   output logic       clr_idex,
   output logic       en_exmem,
   output logic       clr_exmem,
   output logic       en_memwb,
   output logic       halted,
   output logic       busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;
   logic             halt_req;

   assign load_use = ex_memread && (ex_wbreg != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_wbreg)) || (id_use_rt && (id_rt == ex_wbreg)));
   assign halt_req = wb_syscall && wb_halt_req;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      en_pc     = 1'b1;
      en_ifid   = 1'b1;
      clr_ifid  = 1'b0;
      en_idex   = 1'b1;
      clr_idex  = 1'b0;
      en_exmem  = 1'b1;
      clr_exmem = 1'b0;
      en_memwb  = 1'b1;
      halted    = (state_q == HALT);
      busy      = (state_q == MD_BUSY);

      // Halt wins over everything outside HALT; only the SYSCALL itself retires.
      if (state_q != HALT && halt_req) begin
         en_pc    = 1'b0;
         en_ifid  = 1'b0;
         en_idex  = 1'b0;
         en_exmem = 1'b0;
         state_d  = HALT;
         cnt_d    = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (ex_muldiv) begin
                  en_pc     = 1'b0;
                  en_ifid   = 1'b0;
                  en_idex   = 1'b0;
                  clr_exmem = 1'b1;
                  cnt_d     = CNT_W'(MULDIV_LAT - 2);
                  state_d   = MD_BUSY;
               end else if (ex_branch_taken) begin
                  clr_ifid = 1'b1;
                  clr_idex = 1'b1;
               end else if (load_use) begin
                  en_pc    = 1'b0;
                  en_ifid  = 1'b0;
                  clr_idex = 1'b1;
               end
            end
            MD_BUSY: begin
               // cnt==0 is the release cycle: the mult/div leaves EX, so ex_muldiv is ignored.
               if (cnt_q != '0) begin
                  en_pc     = 1'b0;
                  en_ifid   = 1'b0;
                  en_idex   = 1'b0;
                  clr_exmem = 1'b1;
                  cnt_d     = cnt_q - CNT_W'(1);
               end else begin
                  state_d = RUN;
               end
            end
            HALT: begin
               en_pc    = 1'b0;
               en_ifid  = 1'b0;
               en_idex  = 1'b0;
               en_exmem = 1'b0;
               en_memwb = 1'b0;
               if (resume) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end

      // Pipeline free-runs while reset is held.
      if (!rst_n) begin
         en_pc     = 1'b1;
         en_ifid   = 1'b1;
         clr_ifid  = 1'b0;
         en_idex   = 1'b1;
         clr_idex  = 1'b0;
         en_exmem  = 1'b1;
         clr_exmem = 1'b0;
         en_memwb  = 1'b1;
         halted    = 1'b0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (!en_pc && state_q != HALT) perf_stall_q <= perf_stall_q + 32'd1;
         if (clr_ifid)                  perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then randomized traffic,
// each cycle's expected control vector comes from a cycle-counting reference model.
module tb_pipe_hazard_ctrl;

   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_wbreg;
   logic       id_use_rs, id_use_rt, ex_memread, ex_branch_taken, ex_muldiv;
   logic       wb_syscall, wb_halt_req, resume;
   logic       en_pc, en_ifid, clr_ifid, en_idex, clr_idex, en_exmem, clr_exmem, en_memwb;
   logic       halted, busy;

   pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_memread(ex_memread), .ex_wbreg(ex_wbreg), .ex_branch_taken(ex_branch_taken),
      .ex_muldiv(ex_muldiv), .wb_syscall(wb_syscall), .wb_halt_req(wb_halt_req),
      .resume(resume),
      .en_pc(en_pc), .en_ifid(en_ifid), .clr_ifid(clr_ifid), .en_idex(en_idex),
      .clr_idex(clr_idex), .en_exmem(en_exmem), .clr_exmem(clr_exmem),
      .en_memwb(en_memwb), .halted(halted), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] vec;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   txn        = 0;

   // Reference model: remaining EX cycles of the current mult/div and a halted flag.
   int md_left   = 0;
   bit halted_m  = 0;

   task automatic step(input string tag, input bit rst,
                       input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                       input bit mr, input logic [4:0] wb, input bit br, input bit md,
                       input bit sc, input bit hr, input bit rsm);
      bit p, fi, ci, fd, cd, fe, ce, fw, h, b, lu;
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = ~rst; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_memread = mr; ex_wbreg = wb; ex_branch_taken = br; ex_muldiv = md;
      wb_syscall = sc; wb_halt_req = hr; resume = rsm;

      lu = mr && (wb != 0) && ((urs && rs == wb) || (urt && rt == wb));
      {p, fi, ci, fd, cd, fe, ce, fw, h, b} = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      if (rst) begin
         md_left  = 0;
         halted_m = 0;
      end else if (halted_m) begin
         {p, fi, fd, fe, fw, h} = 6'b000001;
         if (rsm) halted_m = 0;
      end else if (sc && hr) begin
         b = (md_left > 0);
         {p, fi, fd, fe} = 4'b0000;
         halted_m = 1;
         md_left  = 0;
      end else if (md_left > 0) begin
         b = 1'b1;
         if (md_left > 1) begin
            {p, fi, fd, ce} = 4'b0001;
         end
         md_left = md_left - 1;
      end else if (md) begin
         {p, fi, fd, ce} = 4'b0001;
         md_left = LAT - 1;
      end else if (br) begin
         ci = 1'b1;
         cd = 1'b1;
      end else if (lu) begin
         p  = 1'b0;
         fi = 1'b0;
         cd = 1'b1;
      end
      e.vec = {p, fi, ci, fd, cd, fe, ce, fw, h, b};
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare at the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = sb_q.pop_front();
            got = {en_pc, en_ifid, clr_ifid, en_idex, clr_idex, en_exmem, clr_exmem,
                   en_memwb, halted, busy};
            compared++;
            txn++;
            if (got !== e.vec) begin
               mismatched++;
               $display("FAIL %s txn=%0d got=%b expected=%b (pc ifid cifid idex cidex exmem cexmem memwb halted busy)",
                        e.tag, txn, got, e.vec);
            end else begin
               $display("txn %0d %s ok vec=%b", txn, e.tag, got);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout compared=%0d", compared);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; id_rs = '0; id_rt = '0; ex_wbreg = '0;
      id_use_rs = 0; id_use_rt = 0; ex_memread = 0; ex_branch_taken = 0; ex_muldiv = 0;
      wb_syscall = 0; wb_halt_req = 0; resume = 0;

      // Reset held with hazards present: outputs must still be free-running.
      step("reset", 1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 1, 1, 1, 0);
      step("reset", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
      idle("run", 2);

      step("loaduse", 0, 5'd8, 5'd3, 1, 0, 1, 5'd8, 0, 0, 0, 0, 0);
      idle("after_lu", 1);
      step("loaduse_rt", 0, 5'd4, 5'd9, 0, 1, 1, 5'd9, 0, 0, 0, 0, 0);
      step("wbreg_zero", 0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0);
      step("br_over_lu", 0, 5'd8, 5'd3, 1, 0, 1, 5'd8, 1, 0, 0, 0, 0);
      idle("run", 1);

      for (int i = 0; i < 4; i++) step("muldiv", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0, 0);
      idle("after_md", 2);

      step("halt_entry", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) step("halt_hold", 0, 5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 1, 1, 1, 0);
      step("resume", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, 1);
      idle("after_resume", 2);

      step("md_entry", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
      step("md_busy", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
      step("rst_mid_busy", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
      idle("after_rst", 3);

      step("md_entry", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
      step("halt_in_busy", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 0);
      step("halt_hold", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
      step("resume", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1);
      idle("after_resume", 1);

      for (int i = 0; i < 500; i++) begin
         bit sc, hr;
         sc = ($urandom_range(0, 99) < 6);
         hr = ($urandom_range(0, 99) < 60);
         step("random", ($urandom_range(0, 99) < 1),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), 5'($urandom_range(0, 7)),
              ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
              sc, hr, ($urandom_range(0, 99) < 20));
      end

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain pending=%0d expected=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces every stage EN/CLR from hazard inputs: load-use stall, taken-branch flush, multi-cycle mult/div occupancy in EX, and SYSCALL halt at WB.
- Purely control: it holds no datapath state; the pipeline registers consume its outputs directly.

Parameters:
- MULDIV_LAT, 4, cycles a mult/div occupies EX (legal range 2..15).
- CNT_W, 4, width of the internal busy counter (must hold MULDIV_LAT-2).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  async active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load
- ex_wbreg  in  5  EX destination register number
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_muldiv  in  1  EX holds mult/div/multu/divu
- wb_syscall  in  1  WB holds SYSCALL
- wb_halt_req  in  1  SYSCALL service value equals 10 (halt)
- resume  in  1  pulse that leaves HALT
- en_pc  out  1  PC write enable
- en_ifid, clr_ifid  out  1 each  IF/ID enable and synchronous clear
- en_idex, clr_idex  out  1 each  ID/EX enable and synchronous clear
- en_exmem, clr_exmem  out  1 each  EX/MEM enable and synchronous clear
- en_memwb  out  1  MEM/WB enable
- halted  out  1  pipeline frozen by SYSCALL halt
- busy  out  1  FSM is in MD_BUSY

Behaviour:
- FSM states: RUN, MD_BUSY, HALT. Reset forces RUN and cnt=0.
- Outputs are combinational from state, cnt and inputs; state and cnt are registered.
- While rst_n is low, all en_* are 1, all clr_* are 0, and halted=busy=0.
- Load-use (lu) = ex_memread & ex_wbreg!=0 & ((id_use_rs & id_rs==ex_wbreg) | (id_use_rt & id_rt==ex_wbreg)).
- Priority in RUN, highest first: halt, muldiv, branch, load-use.
- HALT entry, from RUN or MD_BUSY: wb_syscall & wb_halt_req.
  - Entry cycle: en_memwb=1 (SYSCALL retires), all other en_*=0, all clr_*=0.
  - Next state is HALT.
  - Entry from MD_BUSY abandons the mult/div count.
- HALT: all en_*=0, all clr_*=0, halted=1. resume=1 returns to RUN next cycle. A halt request arriving in the same cycle as resume is ignored.
- RUN & ex_muldiv:
  - en_pc=en_ifid=en_idex=0, clr_exmem=1 (bubble), en_memwb=1.
  - cnt <= MULDIV_LAT-2; next state MD_BUSY.
  - branch and lu are ignored this cycle.
- MD_BUSY, cnt!=0: same freeze as the muldiv entry cycle; cnt decrements; busy=1.
- MD_BUSY, cnt==0: all en_*=1, no clears, busy=1; next state RUN.
  - ex_muldiv is ignored this cycle, because the instruction is leaving EX.
  - Net effect: mult/div occupies EX exactly MULDIV_LAT cycles.
- RUN & ex_branch_taken (no muldiv): all en_*=1, clr_ifid=1, clr_idex=1. This flushes the 2 wrong-path instructions; lu is ignored.
- RUN & lu only: en_pc=en_ifid=0, clr_idex=1, all other en_*=1. Exactly 1 bubble; the next cycle re-evaluates with the load in MEM.
- RUN, no event: all en_*=1, all clr_*=0.
- clr_exmem is asserted only in the mult/div freeze cycles.
- Async reset mid-MD_BUSY or mid-HALT returns to RUN immediately; the counter is discarded.

Optional Feature:
- Macro HAZARD_PERF_EN adds outputs perf_stall (32 bits) and perf_flush (32 bits), reset to 0, wrapping at 2^32.
  - perf_stall increments on every cycle with en_pc=0 outside HALT.
  - perf_flush increments on every cycle with clr_ifid=1.
- Without the macro these ports do not exist and no counters are synthesized.

Test Plan:
- Load-use: ex_memread=1, ex_wbreg=8, id_rs=8, id_use_rs=1 for 1 cycle -> en_pc=en_ifid=0 and clr_idex=1 for exactly 1 cycle, then all en_*=1.
- wbreg zero: same as load-use but ex_wbreg=0, id_rs=0 -> no stall, all en_*=1.
- Branch over load-use: ex_branch_taken=1 together with the load-use condition -> clr_ifid=clr_idex=1, en_pc=1, no stall.
- Mult/div with MULDIV_LAT=4: ex_muldiv held high -> en_pc=0 and clr_exmem=1 for 3 consecutive cycles, busy=1 for cycles 2-4, en_pc=1 on cycle 4, state back to RUN on cycle 5.
- Halt: wb_syscall=1, wb_halt_req=1 -> next cycle halted=1 and all en_*=0; held 10 cycles; resume pulse -> halted=0 and all en_*=1 next cycle.
- Reset mid-busy: rst_n low in the 2nd MD_BUSY cycle -> busy=0 immediately; after release the pipeline runs with all en_*=1.
